// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared constants and types for the lane mux/demux pair.
//            LANES     - number of lanes per frame
//            PH_W      - width of the frame phase counter
//            IDLE_BYTE - byte driven in slots that carry no valid data
//            ph_t      - frame phase type (one value per lane slot)
// Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;
  localparam int         LANES     = 4;
  localparam int         PH_W      = 2;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  typedef logic [PH_W-1:0] ph_t;
endpackage
`default_nettype wire

// File: rtl/mux_phase_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mux_phase_ctr
// Purpose  : Free-running frame phase counter. Starts at 0 after reset,
//            advances every cycle and wraps after the last lane slot.
// Ports    : cclk       - stream clock
//            reset_L    - asynchronous active-low reset
//            ph         - current lane slot (registered)
//            lane_ready - high in the last slot of the frame; the edge that
//                         closes this cycle is the lane load edge
// Revision : 1.0 - initial release
// ============================================================================
module mux_phase_ctr
  import mux_pkg::*;
(
  input  logic cclk,
  input  logic reset_L,
  output ph_t  ph,
  output logic lane_ready
);

  localparam ph_t c_last_ph = ph_t'(LANES - 1);

  ph_t r_ph;

  always_ff @(posedge cclk or negedge reset_L) begin
    if (!reset_L) begin
      r_ph <= '0;
    end else begin
      r_ph <= ph_t'(r_ph + 1'b1);
    end
  end

  assign ph = r_ph;

  // Pure decode of the counter register: no input ever reaches lane_ready.
  assign lane_ready = (r_ph == c_last_ph);

endmodule
`default_nettype wire

// File: rtl/mux_l4a1.sv
`default_nettype none
// ============================================================================
// Module   : mux_l4a1
// Purpose  : Four-lane to single-stream byte multiplexer. All four lanes are
//            captured together once per 4-cycle frame and then emitted one
//            lane per cycle in fixed order 0,1,2,3.
// Ports    : cclk          - stream clock
//            reset_L       - asynchronous active-low reset
//            data_in0..3   - lane bytes, sampled at the end of lane_ready
//            valid0..3     - lane byte qualifiers, sampled with the data
//            lane_ready    - high in the cycle whose closing edge samples lanes
//            data_out      - serialized byte (idle byte in invalid slots)
//            valid_out     - qualifier for data_out
//            frame_sync    - high in the cycle data_out carries lane 0
// Build    : MUX_HOLD_LAST_EN - when defined, an invalid slot repeats the
//            last byte that was driven with valid_out high instead of the
//            idle byte. valid_out, frame_sync and timing are unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module mux_l4a1
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             cclk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             valid2,
  input  logic             valid3,
  output logic             lane_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             frame_sync
);

  ph_t                         w_ph;
  logic [LANES-1:0][WIDTH-1:0] w_lane_data;
  logic [LANES-1:0]            w_lane_valid;
  logic [WIDTH-1:0]            w_slot_data;
  logic                        w_slot_valid;
  logic [WIDTH-1:0]            w_idle_data;

  logic [LANES-1:0][WIDTH-1:0] r_hold;
  logic [LANES-1:0]            r_hvalid;

  mux_phase_ctr u_phase_ctr (
    .cclk       (cclk),
    .reset_L    (reset_L),
    .ph         (w_ph),
    .lane_ready (lane_ready)
  );

  assign w_lane_data  = {data_in3, data_in2, data_in1, data_in0};
  assign w_lane_valid = {valid3, valid2, valid1, valid0};

  // Read side of the hold registers. At the load edge the slot being read is
  // lane 3 of the previous frame; the non-blocking update guarantees that read
  // still sees the old contents.
  assign w_slot_data  = r_hold[w_ph];
  assign w_slot_valid = r_hvalid[w_ph];

`ifdef MUX_HOLD_LAST_EN
  logic [WIDTH-1:0] r_last;

  // Tracks the most recent byte driven with valid_out high.
  always_ff @(posedge cclk or negedge reset_L) begin
    if (!reset_L) begin
      r_last <= '0;
    end else if (w_slot_valid) begin
      r_last <= w_slot_data;
    end
  end

  assign w_idle_data = r_last;
`else
  assign w_idle_data = WIDTH'(IDLE_BYTE);
`endif

  // Capture: all lanes at once, only on the load edge.
  always_ff @(posedge cclk or negedge reset_L) begin
    if (!reset_L) begin
      r_hold   <= '0;
      r_hvalid <= '0;
    end else if (lane_ready) begin
      r_hold   <= w_lane_data;
      r_hvalid <= w_lane_valid;
    end
  end

  // Output slot mux, registered. Invalid lanes still consume their slot.
  always_ff @(posedge cclk or negedge reset_L) begin
    if (!reset_L) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_sync <= 1'b0;
    end else begin
      valid_out  <= w_slot_valid;
      data_out   <= w_slot_valid ? w_slot_data : w_idle_data;
      frame_sync <= (w_ph == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_l4a1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_l4a1
// Purpose  : Self-checking bench for mux_l4a1. A reference model turns every
//            sampled frame into four expected output slots that are queued
//            and compared one per clock edge. Build option MUX_HOLD_LAST_EN
//            selects the matching idle-byte rule in the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_l4a1;

  localparam int WIDTH = 8;

  logic             cclk = 1'b0;
  logic             reset_L;
  logic [WIDTH-1:0] data_in0, data_in1, data_in2, data_in3;
  logic             valid0, valid1, valid2, valid3;
  logic             lane_ready;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             frame_sync;

  always #5 cclk = ~cclk;

  mux_l4a1 #(.WIDTH(WIDTH)) dut (
    .cclk       (cclk),
    .reset_L    (reset_L),
    .data_in0   (data_in0),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .data_in3   (data_in3),
    .valid0     (valid0),
    .valid1     (valid1),
    .valid2     (valid2),
    .valid3     (valid3),
    .lane_ready (lane_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .frame_sync (frame_sync)
  );

  // One expected output slot.
  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       fsync;
  } slot_t;

  slot_t      exp_q[$];
  int         edges;      // rising edges since reset release
  logic [7:0] last_byte;  // last byte driven with valid high
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  // Model reset: four idle slots precede the first sampled frame.
  task automatic model_reset();
    exp_q.delete();
    edges     = 0;
    last_byte = 8'h00;
    for (int i = 0; i < 4; i++) exp_q.push_back('{valid: 1'b0, data: 8'h00, fsync: (i == 0)});
  endtask

  task automatic drive(input logic [3:0][7:0] d, input logic [3:0] v);
    data_in0 = d[0]; data_in1 = d[1]; data_in2 = d[2]; data_in3 = d[3];
    valid0 = v[0]; valid1 = v[1]; valid2 = v[2]; valid3 = v[3];
  endtask

  task automatic drive_garbage();
    drive({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 4'($urandom));
  endtask

  // One clock: check lane_ready, let an edge happen, check the output slot.
  task automatic tick();
    logic       load;
    logic [3:0][7:0] d;
    logic [3:0] v;
    slot_t      e;
    logic [7:0] exp_data;
    load = ((edges % 4) == 3);
    chk("lane_ready", 32'(lane_ready), 32'(load));
    d = {data_in3, data_in2, data_in1, data_in0};
    v = {valid3, valid2, valid1, valid0};
    @(posedge cclk);
    edges++;
    if (load)
      for (int i = 0; i < 4; i++) exp_q.push_back('{valid: v[i], data: d[i], fsync: (i == 0)});
    #1;
    if (exp_q.size() == 0) begin
      chk("model_queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
`ifdef MUX_HOLD_LAST_EN
      exp_data = e.valid ? e.data : last_byte;
`else
      exp_data = e.valid ? e.data : 8'h00;
`endif
      if (e.valid) last_byte = e.data;
      chk("valid_out", 32'(valid_out), 32'(e.valid));
      chk("data_out", 32'(data_out), 32'(exp_data));
      chk("frame_sync", 32'(frame_sync), 32'(e.fsync));
    end
  endtask

  // Wait (with garbage on the lanes) until the lane_ready cycle, then present a frame.
  task automatic send(input logic [3:0][7:0] d, input logic [3:0] v);
    while ((edges % 4) != 3) begin
      drive_garbage();
      tick();
    end
    drive(d, v);
    tick();
    drive_garbage();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'd0);
    chk({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    chk({tag, "_frame_sync"}, 32'(frame_sync), 32'd0);
    chk({tag, "_lane_ready"}, 32'(lane_ready), 32'd0);
  endtask

  initial begin
    // Reset state.
    reset_L = 1'b0;
    drive('0, 4'b0000);
    repeat (2) @(posedge cclk);
    #1 check_reset_outputs("reset");
    @(negedge cclk);
    reset_L = 1'b1;
    model_reset();

    // Idle with all valids low.
    repeat (12) tick();

    // Single frame, all lanes valid.
    send({8'hA3, 8'hA2, 8'hA1, 8'hA0}, 4'b1111);
    repeat (4) tick();

    // Back-to-back frames on consecutive lane_ready cycles.
    send({8'h13, 8'h12, 8'h11, 8'h10}, 4'b1111);
    send({8'h23, 8'h22, 8'h21, 8'h20}, 4'b1111);
    repeat (4) tick();

    // Lane 2 invalid.
    send({8'h55, 8'h55, 8'h55, 8'h55}, 4'b1011);
    repeat (4) tick();

    // Randomized frames with random valids and garbage between loads.
    for (int f = 0; f < 40; f++)
      send({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 4'($urandom));
    repeat (4) tick();

    // Reset mid-frame, right after lane 1 was driven.
    send({8'hC3, 8'hC2, 8'hC1, 8'hC0}, 4'b1111);
    tick();
    tick();
    reset_L = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge cclk);
    #1 check_reset_outputs("midreset_hold");
    @(negedge cclk);
    reset_L = 1'b1;
    model_reset();

    // Four idle cycles, then a fresh frame in order.
    drive('0, 4'b0000);
    repeat (3) tick();
    send({8'hD3, 8'hD2, 8'hD1, 8'hD0}, 4'b1111);
    repeat (4) tick();

    // Random mid-frame resets at varying phases.
    for (int r = 0; r < 4; r++) begin
      send({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 4'($urandom));
      repeat (r) tick();
      #2 reset_L = 1'b0;
      #1 check_reset_outputs("randreset");
      @(negedge cclk);
      reset_L = 1'b1;
      model_reset();
      send({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 4'b1111);
      repeat (4) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
